sat_round: RTL and testbench

- Parametrised, pipelined requantiser for signed sample streams.
- Drops LSH LSBs using a selectable rounding mode, then saturates the result to OSZ bits.
- Tracks saturation per channel with sticky flags and keeps a global saturation-event counter.
- Sits between wide accumulators (filters, mixers) and narrow datapaths (DAC, output muxes); time-multiplexed channels are identified by a tag that travels with each sample.

---
 rtl/sat_round_if.sv | 28 ++
 rtl/sat_round.sv | 199 +++++++++++++++++++
 tb/tb_sat_round.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sat_round_if.sv
// sat_round_if: sample stream bundle for the sat_round requantiser.
//   master : upstream side, drives in_valid/in_ch/in/rnd_mode, observes results
//   slave  : requantiser side, consumes input samples, drives out_* and sat flags
interface sat_round_if #(
  parameter int unsigned ISZ = 24,
  parameter int unsigned OSZ = 16,
  parameter int unsigned CHW = 2
);
  logic           in_valid;
  logic [CHW-1:0] in_ch;
  logic [ISZ-1:0] in;
  logic [1:0]     rnd_mode;
  logic           out_valid;
  logic [CHW-1:0] out_ch;
  logic [OSZ-1:0] out;
  logic           sat_hi;
  logic           sat_lo;

  modport master (
    output in_valid, in_ch, in, rnd_mode,
    input  out_valid, out_ch, out, sat_hi, sat_lo
  );

  modport slave (
    input  in_valid, in_ch, in, rnd_mode,
    output out_valid, out_ch, out, sat_hi, sat_lo
  );
endinterface

// File: rtl/sat_round.sv
// sat_round: pipelined requantiser for tagged signed sample streams.
// Drops LSH LSBs with a selectable rounding mode, saturates to OSZ bits, and
// tracks saturation with per-channel sticky flags and a saturating event count.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   sif (slave)  : in_valid/in_ch/in/rnd_mode in, out_valid/out_ch/out/sat_hi/sat_lo out
//   clr          : synchronous clear of sticky flags and sat_cnt
//   sticky       : per-channel saturation-seen flags
//   sat_cnt      : saturating count of saturated output samples
// Latency: sample captured at edge N is presented after edge N+2.
module sat_round #(
  parameter int unsigned ISZ  = 24,
  parameter int unsigned OSZ  = 16,
  parameter int unsigned LSH  = 4,
  parameter int unsigned NCH  = 4,
  parameter int unsigned CHW  = 2,
  parameter int unsigned CNTW = 16,
  parameter bit          WARN = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  sat_round_if.slave      sif,
  input  logic            clr,
  output logic [NCH-1:0]  sticky,
  output logic [CNTW-1:0] sat_cnt
);

  // Rounded value width; one guard bit so the rounding increment never overflows.
  localparam int unsigned W = ISZ - LSH + 1;
  localparam logic [OSZ-1:0] MaxVal = {1'b0, {(OSZ-1){1'b1}}};
  localparam logic [OSZ-1:0] MinVal = {1'b1, {(OSZ-1){1'b0}}};

  // Sample capture
  logic           v0_q;
  logic [CHW-1:0] ch0_q;
  logic [ISZ-1:0] in0_q;
  logic [1:0]     mode0_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v0_q    <= 1'b0;
      ch0_q   <= '0;
      in0_q   <= '0;
      mode0_q <= 2'b00;
    end else begin
      v0_q <= sif.in_valid;
      if (sif.in_valid) begin
        ch0_q   <= sif.in_ch;
        in0_q   <= sif.in;
        mode0_q <= sif.rnd_mode;
      end
    end
  end

  // Stage 1: rounding
  logic [W-1:0] q;
  logic         h;
  logic         t;
  logic         inc;
  logic [W-1:0] r_d;

  assign q = {in0_q[ISZ-1], in0_q[ISZ-1:LSH]};
  assign h = in0_q[LSH-1];

  if (LSH > 1) begin : g_sticky_bits
    assign t = |in0_q[LSH-2:0];
  end else begin : g_no_sticky_bits
    assign t = 1'b0;
  end

  always_comb begin
    inc = 1'b0;
    case (mode0_q)
      2'b01:   inc = h;
      2'b10:   inc = h & (t | q[0]);  // ties go to the even neighbour
      default: inc = 1'b0;
    endcase
  end

  assign r_d = q + {{(W-1){1'b0}}, inc};

  logic           v1_q;
  logic [CHW-1:0] ch1_q;
  logic [W-1:0]   r1_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q  <= 1'b0;
      ch1_q <= '0;
      r1_q  <= '0;
    end else begin
      v1_q <= v0_q;
      if (v0_q) begin
        ch1_q <= ch0_q;
        r1_q  <= r_d;
      end
    end
  end

  // Stage 2: saturation. r fits in OSZ bits iff its top W-OSZ+1 bits are all equal.
  logic [W-OSZ:0] upper;
  logic           in_range;
  logic           hi_c;
  logic           lo_c;
  logic           sat_c;
  logic [OSZ-1:0] out_c;

  assign upper    = r1_q[W-1:OSZ-1];
  assign in_range = (&upper) | ~(|upper);
  assign hi_c     = ~in_range & ~r1_q[W-1];
  assign lo_c     = ~in_range & r1_q[W-1];
  assign sat_c    = hi_c | lo_c;

  always_comb begin
    out_c = r1_q[OSZ-1:0];
    if (hi_c) begin
      out_c = MaxVal;
    end else if (lo_c) begin
      out_c = MinVal;
    end
  end

  logic           out_valid_q;
  logic [CHW-1:0] out_ch_q;
  logic [OSZ-1:0] out_q;
  logic           sat_hi_q;
  logic           sat_lo_q;

  // Result fields only load on a valid sample so they hold between pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_q       <= '0;
      sat_hi_q    <= 1'b0;
      sat_lo_q    <= 1'b0;
    end else begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        out_ch_q <= ch1_q;
        out_q    <= out_c;
        sat_hi_q <= hi_c;
        sat_lo_q <= lo_c;
      end
    end
  end

  assign sif.out_valid = out_valid_q;
  assign sif.out_ch    = out_ch_q;
  assign sif.out       = out_q;
  assign sif.sat_hi    = sat_hi_q;
  assign sif.sat_lo    = sat_lo_q;

  // Saturation tracking; a coincident event is applied after clr so it survives.
  logic [NCH-1:0]  sticky_d;
  logic [NCH-1:0]  sticky_q;
  logic [CNTW-1:0] cnt_d;
  logic [CNTW-1:0] cnt_q;

  always_comb begin
    sticky_d = clr ? '0 : sticky_q;
    cnt_d    = clr ? '0 : cnt_q;
    if (v1_q && sat_c) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (ch1_q == CHW'(i)) begin
          sticky_d[i] = 1'b1;
        end
      end
      if (cnt_d != '1) begin
        cnt_d = cnt_d + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sticky  = sticky_q;
  assign sat_cnt = cnt_q;

`ifndef SYNTHESIS
  if (WARN) begin : g_warn
    always_ff @(posedge clk) begin
      if (reset_n && v1_q && sat_c) begin
        $display("%m: t=%0t saturation r=%0d limit=%0d", $time, $signed(r1_q),
                 $signed(out_c));
      end
    end
  end
`endif

endmodule

// File: tb/tb_sat_round.sv
// tb_sat_round: directed bench for sat_round. Two instances share the stimulus:
// dut_a uses default parameters, dut_b uses CNTW=2 to exercise counter hold.
// A behavioural model (integer arithmetic on the sample value) is compared with
// both instances on every falling edge; literal checks pin the model.
module tb_sat_round;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic clr;

  always #5 clk = ~clk;

  sat_round_if #(.ISZ(24), .OSZ(16), .CHW(2)) ifa ();
  sat_round_if #(.ISZ(24), .OSZ(16), .CHW(2)) ifb ();

  assign ifb.in_valid = ifa.in_valid;
  assign ifb.in_ch    = ifa.in_ch;
  assign ifb.in       = ifa.in;
  assign ifb.rnd_mode = ifa.rnd_mode;

  logic [3:0]  sticky_a;
  logic [3:0]  sticky_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  sat_round #(.WARN(1'b1)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .sif     (ifa),
    .clr     (clr),
    .sticky  (sticky_a),
    .sat_cnt (cnt_a)
  );

  sat_round #(.CNTW(2), .WARN(1'b0)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .sif     (ifb),
    .clr     (clr),
    .sticky  (sticky_b),
    .sat_cnt (cnt_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic longint round_ref(input logic [23:0] d, input logic [1:0] m);
    longint x, q, f;
    x = longint'($signed(d));
    q = x >>> 4;        // floor(x / 16)
    f = x - q * 16;     // fraction in sixteenths, 0..15
    case (m)
      2'b01:   return q + ((f >= 8) ? 1 : 0);
      2'b10: begin
        if (f > 8) return q + 1;
        else if (f == 8) return q + (q & 1);
        else return q;
      end
      default: return q;
    endcase
  endfunction

  function automatic logic [15:0] clamp16(input longint r);
    logic [63:0] v;
    if (r > 32767) return 16'h7fff;
    if (r < -32768) return 16'h8000;
    v = r;
    return v[15:0];
  endfunction

  function automatic logic [3:0] next_sticky(input logic [3:0] cur, input logic c,
                                             input logic ev, input logic [1:0] ch);
    logic [3:0] n;
    n = c ? 4'b0000 : cur;
    if (ev) n[ch] = 1'b1;
    return n;
  endfunction

  function automatic int next_cnt(input int cur, input logic c, input logic ev, input int lim);
    int n;
    n = c ? 0 : cur;
    if (ev && n < lim) n++;
    return n;
  endfunction

  logic        m0_v  = 1'b0;
  logic [1:0]  m0_ch = '0;
  logic [23:0] m0_d  = '0;
  logic [1:0]  m0_m  = '0;
  logic        m1_v  = 1'b0;
  logic [1:0]  m1_ch = '0;
  longint      m1_r  = 0;
  logic        e_v   = 1'b0;
  logic [1:0]  e_ch  = '0;
  logic [15:0] e_out = '0;
  logic        e_hi  = 1'b0;
  logic        e_lo  = 1'b0;
  logic [3:0]  e_sticky = '0;
  int          e_cnt_a  = 0;
  int          e_cnt_b  = 0;

  wire m1_sat = m1_v && (m1_r > 32767 || m1_r < -32768);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0_v <= 1'b0; m0_ch <= '0; m0_d <= '0; m0_m <= '0;
      m1_v <= 1'b0; m1_ch <= '0; m1_r <= 0;
      e_v <= 1'b0; e_ch <= '0; e_out <= '0; e_hi <= 1'b0; e_lo <= 1'b0;
      e_sticky <= '0; e_cnt_a <= 0; e_cnt_b <= 0;
    end else begin
      e_v <= m1_v;
      if (m1_v) begin
        e_ch  <= m1_ch;
        e_out <= clamp16(m1_r);
        e_hi  <= m1_r > 32767;
        e_lo  <= m1_r < -32768;
      end
      e_sticky <= next_sticky(e_sticky, clr, m1_sat, m1_ch);
      e_cnt_a  <= next_cnt(e_cnt_a, clr, m1_sat, 65535);
      e_cnt_b  <= next_cnt(e_cnt_b, clr, m1_sat, 3);
      m1_v <= m0_v;
      if (m0_v) begin
        m1_ch <= m0_ch;
        m1_r  <= round_ref(m0_d, m0_m);
      end
      m0_v <= ifa.in_valid;
      if (ifa.in_valid) begin
        m0_ch <= ifa.in_ch;
        m0_d  <= ifa.in;
        m0_m  <= ifa.rnd_mode;
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    check("out_valid_a", {31'b0, ifa.out_valid}, {31'b0, e_v});
    check("out_ch_a",    {30'b0, ifa.out_ch},    {30'b0, e_ch});
    check("out_a",       {16'b0, ifa.out},       {16'b0, e_out});
    check("sat_hi_a",    {31'b0, ifa.sat_hi},    {31'b0, e_hi});
    check("sat_lo_a",    {31'b0, ifa.sat_lo},    {31'b0, e_lo});
    check("sticky_a",    {28'b0, sticky_a},      {28'b0, e_sticky});
    check("sat_cnt_a",   {16'b0, cnt_a},         e_cnt_a);
    check("out_valid_b", {31'b0, ifb.out_valid}, {31'b0, e_v});
    check("out_b",       {16'b0, ifb.out},       {16'b0, e_out});
    check("sticky_b",    {28'b0, sticky_b},      {28'b0, e_sticky});
    check("sat_cnt_b",   {30'b0, cnt_b},         e_cnt_b);
    check("hi_lo_excl",  {31'b0, ifa.sat_hi & ifa.sat_lo}, 32'd0);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [1:0] ch, input logic [23:0] d,
                       input logic [1:0] m, input logic c);
    @(negedge clk);
    #1;
    ifa.in_valid = v;
    ifa.in_ch    = ch;
    ifa.in       = d;
    ifa.rnd_mode = m;
    clr          = c;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'b00, 24'h0, 2'b00, 1'b0);
  endtask

  // One sample, then check its result exactly two edges later.
  task automatic lit_sample(input string name, input logic [1:0] ch, input logic [23:0] d,
                            input logic [1:0] m, input logic [15:0] exp_out,
                            input logic exp_hi, input logic exp_lo);
    drive(1'b1, ch, d, m, 1'b0);
    idle(1);
    @(negedge clk);
    check({name, "_nv"}, {31'b0, ifa.out_valid}, 32'd0);
    #1;
    ifa.in_valid = 1'b0;
    @(negedge clk);
    check({name, "_valid"}, {31'b0, ifa.out_valid}, 32'd1);
    check({name, "_ch"},    {30'b0, ifa.out_ch},    {30'b0, ch});
    check({name, "_out"},   {16'b0, ifa.out},       {16'b0, exp_out});
    check({name, "_hi"},    {31'b0, ifa.sat_hi},    {31'b0, exp_hi});
    check({name, "_lo"},    {31'b0, ifa.sat_lo},    {31'b0, exp_lo});
  endtask

  initial begin
    ifa.in_valid = 1'b0;
    ifa.in_ch    = '0;
    ifa.in       = '0;
    ifa.rnd_mode = '0;
    clr          = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;

    // Idle after reset: everything stays zero
    repeat (5) begin
      @(negedge clk);
      check("idle_valid", {31'b0, ifa.out_valid}, 32'd0);
      check("idle_out",   {16'b0, ifa.out},       32'd0);
      check("idle_cnt",   {16'b0, cnt_a},         32'd0);
    end

    // Rounding mode sweep on channel 1
    lit_sample("m00_18", 2'd1, 24'h000018, 2'b00, 16'h0001, 1'b0, 1'b0);
    lit_sample("m01_18", 2'd1, 24'h000018, 2'b01, 16'h0002, 1'b0, 1'b0);
    lit_sample("m10_18", 2'd1, 24'h000018, 2'b10, 16'h0002, 1'b0, 1'b0);
    lit_sample("m00_28", 2'd1, 24'h000028, 2'b00, 16'h0002, 1'b0, 1'b0);
    lit_sample("m01_28", 2'd1, 24'h000028, 2'b01, 16'h0003, 1'b0, 1'b0);
    lit_sample("m10_28", 2'd1, 24'h000028, 2'b10, 16'h0002, 1'b0, 1'b0);
    lit_sample("m11_28", 2'd1, 24'h000028, 2'b11, 16'h0002, 1'b0, 1'b0);

    // Negative rounding
    lit_sample("neg_m00", 2'd1, 24'hFFFFE8, 2'b00, 16'hFFFE, 1'b0, 1'b0);
    lit_sample("neg_m01", 2'd1, 24'hFFFFE8, 2'b01, 16'hFFFF, 1'b0, 1'b0);
    lit_sample("neg_m10", 2'd1, 24'hFFFFE8, 2'b10, 16'hFFFE, 1'b0, 1'b0);

    // Saturation on channel 2
    lit_sample("sat_hi", 2'd2, 24'h07FFF8, 2'b01, 16'h7FFF, 1'b1, 1'b0);
    check("sticky_ch2", {28'b0, sticky_a}, 32'h4);
    check("cnt_one",    {16'b0, cnt_a},    32'd1);
    lit_sample("max_nosat", 2'd2, 24'h07FFF8, 2'b00, 16'h7FFF, 1'b0, 1'b0);
    lit_sample("sat_lo", 2'd2, 24'h800000, 2'b00, 16'h8000, 1'b0, 1'b1);
    check("cnt_two",    {16'b0, cnt_a},    32'd2);
    check("cnt_b_two",  {30'b0, cnt_b},    32'd2);

    // Clear, then five saturating samples on channel 3
    drive(1'b0, 2'd0, 24'h0, 2'b00, 1'b1);
    idle(1);
    @(negedge clk);
    check("clr_cnt",    {16'b0, cnt_a},    32'd0);
    check("clr_sticky", {28'b0, sticky_a}, 32'd0);
    repeat (5) drive(1'b1, 2'd3, 24'h800000, 2'b00, 1'b0);
    idle(2);
    @(negedge clk);
    check("cnt_b_hold", {30'b0, cnt_b},    32'd3);
    check("cnt_a_five", {16'b0, cnt_a},    32'd5);
    check("sticky_ch3", {28'b0, sticky_b}, 32'h8);

    // Sixth saturation on channel 1 with clr on the same edge as its output
    drive(1'b1, 2'd1, 24'h07FFF8, 2'b01, 1'b0);
    idle(1);
    drive(1'b0, 2'd0, 24'h0, 2'b00, 1'b1);
    @(negedge clk);
    check("clr_ev_valid",  {31'b0, ifa.out_valid}, 32'd1);
    check("clr_ev_hi",     {31'b0, ifa.sat_hi},    32'd1);
    check("clr_ev_cnt_a",  {16'b0, cnt_a},         32'd1);
    check("clr_ev_cnt_b",  {30'b0, cnt_b},         32'd1);
    check("clr_ev_sticky", {28'b0, sticky_b},      32'h2);
    idle(1);

    // Burst then mid-stream reset
    drive(1'b1, 2'd0, 24'h000010, 2'b00, 1'b0);
    drive(1'b1, 2'd1, 24'h000020, 2'b00, 1'b0);
    drive(1'b1, 2'd2, 24'h000030, 2'b00, 1'b0);
    @(negedge clk);
    #1;
    ifa.in_valid = 1'b0;
    reset_n      = 1'b0;
    @(negedge clk);
    check("rst_valid",  {31'b0, ifa.out_valid}, 32'd0);
    check("rst_out",    {16'b0, ifa.out},       32'd0);
    check("rst_ch",     {30'b0, ifa.out_ch},    32'd0);
    check("rst_cnt",    {16'b0, cnt_a},         32'd0);
    check("rst_sticky", {28'b0, sticky_a},      32'd0);
    #1 reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("flush_valid", {31'b0, ifa.out_valid}, 32'd0);
    end
    lit_sample("post_rst", 2'd3, 24'h000050, 2'b00, 16'h0005, 1'b0, 1'b0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
